// File: rtl/l2_access_arbiter_pkg.sv
// Shared types and constants for the L2 access arbiter.
// Also holds a small one-hot to index encoder used by the top level.
package l2_arb_pkg;

  localparam int NUM_CORES = 4;
  localparam int ID_W      = 2;
  localparam int AGE_W     = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(15);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_CORES-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (oh[i]) id = ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/l2_access_arbiter_if.sv
// Core-request / L2-grant bundle between the cores and the L2 access arbiter.
interface l2_arb_if;

  // Handshake: a core raises req_valid (with req_write/req_two_beat stable) and
  // holds it until its grant bit rises; that grant is the acknowledgement. The
  // request may be withdrawn before it is granted. There is no ready signal.
  logic [l2_arb_pkg::NUM_CORES-1:0] req_valid;
  logic [l2_arb_pkg::NUM_CORES-1:0] req_write;
  logic [l2_arb_pkg::NUM_CORES-1:0] req_two_beat;
  logic [l2_arb_pkg::NUM_CORES-1:0] grant;
  logic                             grant_valid;
  logic [l2_arb_pkg::ID_W-1:0]      grant_id;
  logic                             grant_write;
  logic                             grant_beat;
  logic [l2_arb_pkg::NUM_CORES-1:0] rewrite_bcast;
  logic                             starve_alert;

  modport master (
    output req_valid, req_write, req_two_beat,
    input  grant, grant_valid, grant_id, grant_write, grant_beat,
           rewrite_bcast, starve_alert
  );

  modport slave (
    input  req_valid, req_write, req_two_beat,
    output grant, grant_valid, grant_id, grant_write, grant_beat,
           rewrite_bcast, starve_alert
  );

endinterface

// File: rtl/l2_access_arbiter_rr_pick4.sv
// Four-way round-robin picker: first set request after ptr, wrapping around.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       any
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    gnt   = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    // k = 4 wraps back onto ptr itself, so the last owner is considered last.
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/l2_access_arbiter.sv
// Arbitrates four cores onto the single-port L2: writes before reads, round-robin
// within each class, with an age override; accesses last one or two beats.
module l2_access_arbiter
  import l2_arb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  l2_arb_if.slave  bus,
  output state_e   dbg_state
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [AGE_W-1:0]       age_q [NUM_CORES];
  logic [AGE_W-1:0]       age_d [NUM_CORES];
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic                   grant_write_q, grant_write_d;
  logic                   grant_beat_q, grant_beat_d;
  logic                   two_beat_q, two_beat_d;
  logic                   starve_q, starve_d;

  logic                   last_beat;
  logic                   arb_en;
  logic [NUM_CORES-1:0]   cand;
  logic [NUM_CORES-1:0]   aged;
  logic [NUM_CORES-1:0]   aged_oh;
  logic [NUM_CORES-1:0]   wr_oh, rd_oh;
  logic                   wr_any, rd_any;
  logic [NUM_CORES-1:0]   winner;
  logic [ID_W-1:0]        win_id;
  logic                   pick;

  // Arbitration windows: idle, or the final beat of the current access.
  assign last_beat = ((state_q == BEAT0) && !two_beat_q) || (state_q == BEAT1);
  assign arb_en    = (state_q == IDLE) || last_beat;

  always_comb begin
    cand = '0;
    if (state_q == IDLE) begin
      cand = bus.req_valid;
    end else if (last_beat) begin
      cand = bus.req_valid & ~grant_q;
    end
  end

  always_comb begin
    aged    = '0;
    aged_oh = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      aged[i] = cand[i] && (age_q[i] == AGE_MAX);
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (aged[i] && (aged_oh == '0)) aged_oh[i] = 1'b1;
    end
  end

  rr_pick4 u_pick_wr (
    .req (cand & bus.req_write),
    .ptr (rr_ptr_q),
    .gnt (wr_oh),
    .any (wr_any)
  );

  rr_pick4 u_pick_rd (
    .req (cand & ~bus.req_write),
    .ptr (rr_ptr_q),
    .gnt (rd_oh),
    .any (rd_any)
  );

  always_comb begin
    winner = '0;
    if (aged_oh != '0) begin
      winner = aged_oh;
    end else if (wr_any) begin
      winner = wr_oh;
    end else if (rd_any) begin
      winner = rd_oh;
    end
  end

  assign pick   = |cand;
  assign win_id = onehot_to_id(winner);

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = pick ? BEAT0 : IDLE;
      BEAT0:   state_d = two_beat_q ? BEAT1 : (pick ? BEAT0 : IDLE);
      BEAT1:   state_d = pick ? BEAT0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.grant_valid   = (state_q != IDLE);
    bus.grant         = grant_q;
    bus.grant_id      = grant_id_q;
    bus.grant_write   = grant_write_q;
    bus.grant_beat    = grant_beat_q;
    bus.rewrite_bcast = {NUM_CORES{grant_write_q}} & ~grant_q;
    bus.starve_alert  = starve_q;
    dbg_state         = state_q;
  end

  // Grant bookkeeping: capture on a pick, advance the beat inside a two-beat access.
  always_comb begin
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_write_d = grant_write_q;
    grant_beat_d  = grant_beat_q;
    two_beat_d    = two_beat_q;
    rr_ptr_d      = rr_ptr_q;
    if (arb_en) begin
      if (pick) begin
        grant_d       = winner;
        grant_id_d    = win_id;
        grant_write_d = bus.req_write[win_id];
        two_beat_d    = bus.req_two_beat[win_id];
        grant_beat_d  = 1'b0;
        rr_ptr_d      = win_id;
      end else begin
        grant_d       = '0;
        grant_id_d    = '0;
        grant_write_d = 1'b0;
        two_beat_d    = 1'b0;
        grant_beat_d  = 1'b0;
      end
    end else if (state_q == BEAT0) begin
      grant_beat_d = 1'b1;
    end
  end

  always_comb begin
    starve_d = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      age_d[i] = age_q[i];
      if (!bus.req_valid[i] || (pick && winner[i])) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
      if (age_d[i] == AGE_MAX) starve_d = 1'b1;
    end
  end

  // rr_ptr resets to the last core so core 0 is first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q      <= ID_W'(NUM_CORES - 1);
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_write_q <= 1'b0;
      grant_beat_q  <= 1'b0;
      two_beat_q    <= 1'b0;
      starve_q      <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) age_q[i] <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_write_q <= grant_write_d;
      grant_beat_q  <= grant_beat_d;
      two_beat_q    <= two_beat_d;
      starve_q      <= starve_d;
      for (int i = 0; i < NUM_CORES; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: tb/tb_l2_access_arbiter.sv
// Directed bench for l2_access_arbiter: a cycle model pushes expected outputs,
// each clock pops and compares them, plus spot checks on the key scenarios.
module tb_l2_access_arbiter;
  import l2_arb_pkg::*;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l2_arb_if bus();
  state_e   dbg_state;

  l2_access_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int n_asserts = 0;
  int n_fail    = 0;

  // reference model state
  int          m_state;
  int          m_ptr;
  int          m_age [4];
  logic [3:0]  m_grant;
  int          m_id;
  logic        m_wr, m_beat, m_two, m_alert;

  function automatic logic [15:0] dut_out();
    return {dbg_state, bus.grant_valid, bus.grant, bus.grant_id, bus.grant_write,
            bus.grant_beat, bus.rewrite_bcast, bus.starve_alert};
  endfunction

  function automatic logic [15:0] model_out();
    logic [3:0] bcast;
    bcast = {4{m_wr}} & ~m_grant;
    return {2'(m_state), (m_state != 0), m_grant, 2'(m_id), m_wr, m_beat, bcast, m_alert};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 3;
    for (int i = 0; i < 4; i++) m_age[i] = 0;
    m_grant = 4'b0;
    m_id    = 0;
    m_wr    = 1'b0;
    m_beat  = 1'b0;
    m_two   = 1'b0;
    m_alert = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] rv, rw, rt, cand;
    int win, j;
    bit last_b, arb;
    rv = bus.req_valid;
    rw = bus.req_write;
    rt = bus.req_two_beat;
    last_b = ((m_state == 1) && !m_two) || (m_state == 2);
    arb    = (m_state == 0) || last_b;
    cand   = arb ? (rv & ~m_grant) : 4'b0;
    win = -1;
    for (int i = 0; i < 4; i++)
      if (win < 0 && cand[i] && m_age[i] == 15) win = i;
    if (win < 0 && (cand & rw) != 4'b0) begin
      for (int k = 1; k <= 4; k++) begin
        j = (m_ptr + k) % 4;
        if (win < 0 && cand[j] && rw[j]) win = j;
      end
    end
    if (win < 0) begin
      for (int k = 1; k <= 4; k++) begin
        j = (m_ptr + k) % 4;
        if (win < 0 && cand[j] && !rw[j]) win = j;
      end
    end
    m_alert = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!rv[i] || i == win) m_age[i] = 0;
      else if (m_age[i] < 15) m_age[i] = m_age[i] + 1;
      if (m_age[i] == 15) m_alert = 1'b1;
    end
    if (arb) begin
      if (win >= 0) begin
        m_state = 1;
        m_grant = 4'b0001 << win;
        m_id    = win;
        m_wr    = rw[win];
        m_two   = rt[win];
        m_beat  = 1'b0;
        m_ptr   = win;
      end else begin
        m_state = 0;
        m_grant = 4'b0;
        m_id    = 0;
        m_wr    = 1'b0;
        m_two   = 1'b0;
        m_beat  = 1'b0;
      end
    end else begin
      m_state = 2;
      m_beat  = 1'b1;
    end
    exp_q.push_back(model_out());
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [3:0] t);
    bus.req_valid    = v;
    bus.req_write    = w;
    bus.req_two_beat = t;
  endtask

  task automatic tick(input string tag);
    logic [15:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {16'b0, dut_out()}, {16'b0, e});
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check({tag, "_async"}, {16'b0, dut_out()}, 32'd0);
    drive(4'b0, 4'b0, 4'b0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_hold"}, {16'b0, dut_out()}, 32'd0);
    reset = 1'b1;
  endtask

  logic [3:0] seq [5];
  int seen;

  initial begin
    drive(4'b0, 4'b0, 4'b0);
    #2;

    // 1: single read, one beat
    do_reset("t1_reset");
    drive(4'b0001, 4'b0000, 4'b0000);
    tick("t1_c1");
    check("t1_grant", {28'b0, bus.grant}, 32'h1);
    check("t1_beat", {31'b0, bus.grant_beat}, 32'h0);
    drive(4'b0000, 4'b0000, 4'b0000);
    tick("t1_c2");
    check("t1_gv_drop", {31'b0, bus.grant_valid}, 32'h0);

    // 2: four reads held, strict rotation with no gaps
    do_reset("t2_reset");
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    drive(4'b1111, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick("t2_cyc");
      check("t2_rr_grant", {28'b0, bus.grant}, {28'b0, seq[i]});
    end
    drive(4'b0000, 4'b0000, 4'b0000);
    tick("t2_idle");

    // 3: writer beats reader; snoop broadcast to the others
    do_reset("t3_reset");
    drive(4'b0011, 4'b0010, 4'b0000);
    tick("t3_c1");
    check("t3_wr_first", {28'b0, bus.grant}, 32'h2);
    check("t3_bcast", {28'b0, bus.rewrite_bcast}, 32'hd);
    drive(4'b0001, 4'b0000, 4'b0000);
    tick("t3_c2");
    check("t3_rd_next", {28'b0, bus.grant}, 32'h1);
    drive(4'b0000, 4'b0000, 4'b0000);
    tick("t3_idle");

    // 4: two-beat write; core 0 arrives during BEAT0 while core 2 drops its request
    do_reset("t4_reset");
    drive(4'b0100, 4'b0100, 4'b0100);
    tick("t4_b0");
    check("t4_b0_grant", {28'b0, bus.grant}, 32'h4);
    check("t4_b0_beat", {31'b0, bus.grant_beat}, 32'h0);
    drive(4'b0001, 4'b0000, 4'b0000);
    tick("t4_b1");
    check("t4_b1_grant", {28'b0, bus.grant}, 32'h4);
    check("t4_b1_beat", {31'b0, bus.grant_beat}, 32'h1);
    tick("t4_next");
    check("t4_core0", {28'b0, bus.grant}, 32'h1);
    drive(4'b0000, 4'b0000, 4'b0000);
    tick("t4_idle");

    // 5: core 3 read starved by continuous writers until its age saturates
    do_reset("t5_reset");
    drive(4'b1111, 4'b0111, 4'b0000);
    seen = -1;
    for (int c = 0; c < 40 && seen < 0; c++) begin
      tick("t5_cyc");
      if (bus.starve_alert) seen = c;
    end
    check("t5_alert_seen", {31'b0, bus.starve_alert}, 32'h1);
    check("t5_alert_cycle", 32'(seen), 32'd14);
    tick("t5_grant");
    check("t5_core3", {28'b0, bus.grant}, 32'h8);
    check("t5_alert_drop", {31'b0, bus.starve_alert}, 32'h0);
    drive(4'b0000, 4'b0000, 4'b0000);
    repeat (3) tick("t5_drain");

    // 6: reset in BEAT0 of a two-beat access aborts at once
    do_reset("t6_reset");
    drive(4'b0100, 4'b0000, 4'b0100);
    tick("t6_b0");
    check("t6_in_beat0", {30'b0, dbg_state}, 32'h1);
    do_reset("t6_abort");
    drive(4'b1111, 4'b0000, 4'b0000);
    tick("t6_restart");
    check("t6_core0", {28'b0, bus.grant}, 32'h1);
    drive(4'b0000, 4'b0000, 4'b0000);
    repeat (3) tick("t6_drain");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
